// File: rtl/avalon_bus_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter sharing one RAM port between the
// instruction-fetch master (m0) and the load/store data master (m1).
// One transaction per grant; the grant is held through slave waitrequest stalls,
// and every transaction is followed by one idle cycle.
// Default policy: fixed priority, the data port (m1) wins ties.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the master that did not own
// the last completed transaction.
module avalon_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Master 0: instruction fetch
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  // Master 1: load/store data
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  // Slave: RAM
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  // Status
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_t;

  state_t state_q;
  logic   m0_req;
  logic   m1_req;
  logic   pick_m1;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = m0, 1 = m1; only completed transactions update it.
  logic last_owner_q;

  // On a tie m1 wins only when m0 owned the last completed transaction.
  assign pick_m1 = m1_req & (~m0_req | ~last_owner_q);
`else
  assign pick_m1 = m1_req;
`endif

  // Arbitration FSM with registered grant/busy; both completion and abandon
  // return to idle, which provides the inter-transaction bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant   <= 2'b00;
      busy    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_m1) begin
            state_q <= StGnt1;
            grant   <= 2'b10;
            busy    <= 1'b1;
          end else if (m0_req) begin
            state_q <= StGnt0;
            grant   <= 2'b01;
            busy    <= 1'b1;
          end
        end
        StGnt0: begin
          if (!m0_req || !s_waitrequest) begin
            state_q <= StIdle;
            grant   <= 2'b00;
            busy    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            // Inside this branch m0_req implies a completed access.
            if (m0_req) last_owner_q <= 1'b0;
`endif
          end
        end
        StGnt1: begin
          if (!m1_req || !s_waitrequest) begin
            state_q <= StIdle;
            grant   <= 2'b00;
            busy    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            if (m1_req) last_owner_q <= 1'b1;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          grant   <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Slave-side mux and per-master stall; the non-owner is always stalled.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    unique case (state_q)
      StGnt0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      StGnt1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own waitrequest.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: directed scenarios followed by
// randomized traffic compared against an owner/last-owner reference model.
// Honours ARB_ROUND_ROBIN_EN for the expected tie-break policy.
module tb_avalon_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]    grant;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hf; m1_byteenable = 4'hf;
    s_waitrequest = 1; s_readdata = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; m0_read = 1; m0_address = 32'h04;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL rst_s_read: got %b want 0", s_read); end
      checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest); end
    end
    reset = 0; #1;
    checks++; if (m0_waitrequest !== 1'b1 || grant !== 2'b00) begin
      errors++; $display("FAIL rst_release_idle: wait=%b grant=%b want 1/00", m0_waitrequest, grant);
    end
    tick();
    checks++; if (grant !== 2'b01 || !busy) begin errors++; $display("FAIL rst_first_grant: got %b/%b want 01/1", grant, busy); end
    checks++; if (s_read !== 1'b1 || s_address !== 32'h04) begin
      errors++; $display("FAIL rst_s_bus: read=%b addr=%h want 1/04", s_read, s_address);
    end
    s_waitrequest = 0; s_readdata = 32'h24020090; #1;
    checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h24020090) begin
      errors++; $display("FAIL rst_complete: wait=%b data=%h want 0/24020090", m0_waitrequest, m0_readdata);
    end
    tick(); m0_read = 0; s_waitrequest = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_after: got %b want 00", grant); end
  endtask

  task automatic test_single_fetch;
    m0_read = 1; m0_address = 32'h04; s_waitrequest = 1; #1;
    checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL fetch_arb: grant=%b wait=%b want 00/1", grant, m0_waitrequest);
    end
    tick();
    checks++; if (grant !== 2'b01 || s_address !== 32'h04 || m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL fetch_gnt1: grant=%b addr=%h wait=%b want 01/04/1", grant, s_address, m0_waitrequest);
    end
    tick(); s_waitrequest = 0; s_readdata = 32'h24020090; #1;
    checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b0 || m0_readdata !== 32'h24020090) begin
      errors++; $display("FAIL fetch_done: grant=%b wait=%b data=%h want 01/0/24020090", grant, m0_waitrequest, m0_readdata);
    end
    checks++; if (m1_waitrequest !== 1'b1 || m1_readdata !== 32'h24020090) begin
      errors++; $display("FAIL fetch_other: wait=%b data=%h want 1/24020090", m1_waitrequest, m1_readdata);
    end
    tick(); m0_read = 0; s_waitrequest = 1; #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL fetch_bubble: %b/%b want 00/0", grant, busy); end
  endtask

  task automatic test_contention;
    m0_read = 1; m0_address = 32'h08;
    m1_write = 1; m1_address = 32'h20; m1_writedata = 32'h40; m1_byteenable = 4'hf;
    s_waitrequest = 0; #1;
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL cont_idle_wait: %b/%b want 1/1", m0_waitrequest, m1_waitrequest);
    end
    tick();
    checks++; if (grant !== 2'b10 || s_write !== 1'b1 || s_read !== 1'b0) begin
      errors++; $display("FAIL cont_gnt1: grant=%b w=%b r=%b want 10/1/0", grant, s_write, s_read);
    end
    checks++; if (s_address !== 32'h20 || s_writedata !== 32'h40 || s_byteenable !== 4'hf) begin
      errors++; $display("FAIL cont_wbus: addr=%h wd=%h be=%h want 20/40/f", s_address, s_writedata, s_byteenable);
    end
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL cont_waits: %b/%b want 1/0", m0_waitrequest, m1_waitrequest);
    end
    tick(); m1_write = 0; #1;
    checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL cont_bubble: grant=%b wait=%b want 00/1", grant, m0_waitrequest);
    end
    tick(); s_readdata = 32'h24030050; #1;
    checks++; if (grant !== 2'b01 || s_address !== 32'h08 || m0_waitrequest !== 1'b0 || m0_readdata !== 32'h24030050) begin
      errors++; $display("FAIL cont_gnt0: grant=%b addr=%h wait=%b data=%h", grant, s_address, m0_waitrequest, m0_readdata);
    end
    tick(); m0_read = 0; s_waitrequest = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_end: got %b want 00", grant); end
  endtask

  task automatic test_stall_hold;
    m0_read = 1; m0_address = 32'h0c; m1_read = 1; m1_address = 32'h30; s_waitrequest = 1; #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      m0_read = i[0]; #1;
      checks++; if (grant !== 2'b10 || s_address !== 32'h30) begin
        errors++; $display("FAIL stall_hold%0d: grant=%b addr=%h want 10/30", i, grant, s_address);
      end
      checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
        errors++; $display("FAIL stall_wait%0d: %b/%b want 1/1", i, m0_waitrequest, m1_waitrequest);
      end
      tick();
    end
    m0_read = 1; s_waitrequest = 0; #1;
    checks++; if (grant !== 2'b10 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL stall_done: grant=%b w1=%b w0=%b want 10/0/1", grant, m1_waitrequest, m0_waitrequest);
    end
    tick(); m0_read = 0; m1_read = 0; s_waitrequest = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_end: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid;
    m0_read = 1; m0_address = 32'h10; s_waitrequest = 1; #1;
    tick();
    checks++; if (grant !== 2'b01 || s_read !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt: grant=%b read=%b want 01/1", grant, s_read);
    end
    reset = 1;
    tick();
    checks++; if (grant !== 2'b00 || s_read !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_drop: grant=%b read=%b busy=%b want 00/0/0", grant, s_read, busy);
    end
    reset = 0; #1;
    tick(); s_waitrequest = 0; #1;
    checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b0 || s_address !== 32'h10) begin
      errors++; $display("FAIL rmid_retry: grant=%b wait=%b addr=%h want 01/0/10", grant, m0_waitrequest, s_address);
    end
    tick(); m0_read = 0; s_waitrequest = 1; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_end: got %b want 00", grant); end
  endtask

  task automatic test_back_to_back;
    logic       last;
    logic [1:0] exp;
    reset = 1; tick(); reset = 0;
    last = 1'b1;
    m0_read = 1; m1_read = 1; s_waitrequest = 0; #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (RR && last) ? 2'b01 : 2'b10;
      checks++; if (grant !== exp) begin errors++; $display("FAIL b2b_order%0d: got %b want %b", i, grant, exp); end
      last = exp[1];
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_bubble%0d: got %b want 00", i, grant); end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_random;
    int          owner;
    logic        last;
    logic        req0, req1, rq;
    logic [1:0]  eg;
    logic [69:0] exp_bus, act_bus;
    logic        ew0, ew1;
    owner = -1; last = 1'b1;
    for (int c = 0; c < 400; c++) begin
      reset = (c == 0) || ($urandom_range(0, 59) == 0);
      m0_read = $urandom_range(0, 1); m0_write = ($urandom_range(0, 3) == 0);
      m1_read = $urandom_range(0, 1); m1_write = ($urandom_range(0, 3) == 0);
      m0_address = $urandom; m1_address = $urandom;
      m0_writedata = $urandom; m1_writedata = $urandom;
      m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
      s_readdata = $urandom; s_waitrequest = ($urandom_range(0, 2) == 0);
      #1;
      if (c > 0) begin
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        if (owner == 0) exp_bus = {m0_address, m0_read, m0_write, m0_writedata, m0_byteenable};
        else if (owner == 1) exp_bus = {m1_address, m1_read, m1_write, m1_writedata, m1_byteenable};
        else exp_bus = '0;
        ew0 = (owner == 0) ? s_waitrequest : 1'b1;
        ew1 = (owner == 1) ? s_waitrequest : 1'b1;
        act_bus = {s_address, s_read, s_write, s_writedata, s_byteenable};
        checks++; if (grant !== eg || busy !== (owner >= 0)) begin
          errors++; $display("FAIL rnd_grant c%0d: grant=%b busy=%b want %b/%b", c, grant, busy, eg, owner >= 0);
        end
        checks++; if (act_bus !== exp_bus) begin
          errors++; $display("FAIL rnd_sbus c%0d: got %h want %h", c, act_bus, exp_bus);
        end
        checks++; if (m0_waitrequest !== ew0 || m1_waitrequest !== ew1) begin
          errors++; $display("FAIL rnd_wait c%0d: got %b%b want %b%b", c, m0_waitrequest, m1_waitrequest, ew0, ew1);
        end
        checks++; if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin
          errors++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h", c, m0_readdata, m1_readdata, s_readdata);
        end
      end
      // Reference model: who owns the bus after this clock edge.
      req0 = m0_read | m0_write;
      req1 = m1_read | m1_write;
      if (reset) begin
        owner = -1; last = 1'b1;
      end else if (owner < 0) begin
        if (req1 && (!RR || !req0 || !last)) owner = 1;
        else if (req0) owner = 0;
      end else begin
        rq = (owner == 0) ? req0 : req1;
        if (!rq || !s_waitrequest) begin
          if (rq) last = (owner == 1);
          owner = -1;
        end
      end
      @(posedge clk); #1;
    end
    reset = 0; idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_stall_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter that lets the CPU instruction-fetch port (master 0) and the load/store data port (master 1) share the single Avalon memory-mapped RAM port.
- Sits between top_level_cpu's internal fetch and data units and the RAM.
- Grants the bus to one master per transaction and holds the grant through slave waitrequest stalls.
- Default policy is fixed priority to the data port.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
BE_W, 4, byteenable width (DATA_W/8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
m0_address  in  ADDR_W  fetch master address
m0_read  in  1  fetch read request
m0_write  in  1  fetch write request (normally 0, still arbitrated)
m0_writedata  in  DATA_W  fetch write data
m0_byteenable  in  BE_W  fetch byte enables
m0_readdata  out  DATA_W  fetch read data
m0_waitrequest  out  1  fetch stall
m1_address, m1_read, m1_write, m1_writedata, m1_byteenable  in  as m0  data master request
m1_readdata  out  DATA_W  data read data
m1_waitrequest  out  1  data stall
s_address  out  ADDR_W  to RAM
s_read  out  1  to RAM
s_write  out  1  to RAM
s_writedata  out  DATA_W  to RAM
s_byteenable  out  BE_W  to RAM
s_readdata  in  DATA_W  from RAM
s_waitrequest  in  1  from RAM
grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
busy  out  1  high while state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; all state registers update on posedge clk only.
- Request definition: mX_req = mX_read | mX_write.
- States: IDLE, GNT0, GNT1. Reset forces IDLE.
- Reset values and IDLE outputs: grant=00, busy=0; s_read=0, s_write=0, s_address=0, s_writedata=0, s_byteenable=0; m0_waitrequest=1, m1_waitrequest=1.
- IDLE transitions:
  - m1_req -> GNT1, regardless of m0_req.
  - else m0_req -> GNT0.
  - else stay IDLE.
  - Arbitration latency is 1 cycle: a request asserted in IDLE sees waitrequest=1 for that cycle.
- In GNTx:
  - s_* request signals are combinationally driven from master x.
  - mx_waitrequest = s_waitrequest.
  - The other master's waitrequest is forced to 1.
  - grant = one-hot x, busy = 1.
- Completion: the first cycle in GNTx with mx_req=1 and s_waitrequest=0. Next state is IDLE, so there is one idle bubble between consecutive transactions.
- Abandon: GNTx with mx_req=0 returns to IDLE next cycle, with no slave access issued that cycle.
- Read data: s_readdata is broadcast unchanged to both m0_readdata and m1_readdata. Masters sample it only when their own waitrequest is low.
- Simultaneous read and write from one master: both are passed through unchanged; the slave resolves them.
- Stall: while s_waitrequest=1 the grant is held indefinitely and the other master waits. There is no timeout.
- Reset mid-transaction: the cycle after reset is sampled high, state is IDLE and s_read/s_write are 0. An in-flight access is dropped and the master retries.
- Request changes: a change of a non-granted master's request never affects the current grant.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register, reset value 1, records the master of the last completed transaction.
  - In IDLE with both requests high, grant goes to the master that is not last_owner.
  - A single request is granted directly.
  - Abandoned transactions do not update last_owner.
- Undefined: fixed priority, with m1 always winning ties.

Test Plan:
- Reset check: hold reset 2 cycles with m0_read=1 -> grant=00, busy=0, s_read=0, m0_waitrequest=1. The cycle after release: IDLE sees request; the next cycle grant=01.
- Single fetch: m0_read=1, m0_address=0x04, RAM waitrequest low on 2nd granted cycle -> s_address=0x04 during GNT0, m0_readdata=0x24020090 when m0_waitrequest=0, then grant=00 for one cycle.
- Contention, fixed priority: m0_read=1 at 0x08 and m1_write=1 at 0x20 with writedata=0x40 in the same cycle -> GNT1 first (RAM[0x20]=0x40), then GNT0 fetches 0x24030050. m0_waitrequest stays 1 throughout GNT1.
- Stall hold: in GNT1, RAM holds waitrequest high 5 cycles -> grant stays 10 for 5 cycles, m0 remains stalled, completion on cycle 6.
- Reset mid-transaction: assert reset during GNT0 with s_waitrequest=1 -> next cycle s_read=0, grant=00. After release, m0 is re-granted and completes.
- With ARB_ROUND_ROBIN_EN: both masters request continuously for 4 transactions -> grant order 01,10,01,10 (first is m0 since last_owner resets to 1). Without the macro, the order is 10,10,10,10.
